// File: rtl/ej32_mb8_arb.sv
// ej32_mb8_arb: arbiter and burst sequencer for the 8-bit SPRAM bus.
// Shares the bus between the boot loader (bt), load/store unit (ls) and
// instruction fetch (fe). One requester owns the bus for a burst of
// 1..4 consecutive byte addresses; read bytes return one cycle later.
// Optional feature: define EJ32_ARB_RR_EN for round-robin between ls and
// fe (bt always keeps top priority). Without it, ls strictly beats fe.
module ej32_mb8_arb #(
  parameter int ASZ     = 17,
  parameter bit BT_LOCK = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bt_req,
  input  logic           bt_we,
  input  logic [1:0]     bt_len,
  input  logic [ASZ-1:0] bt_a,
  input  logic [7:0]     bt_d,
  output logic           bt_gnt,
  output logic           bt_vld,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [1:0]     ls_len,
  input  logic [ASZ-1:0] ls_a,
  input  logic [7:0]     ls_d,
  output logic           ls_gnt,
  output logic           ls_vld,
  input  logic           fe_req,
  input  logic           fe_we,
  input  logic [1:0]     fe_len,
  input  logic [ASZ-1:0] fe_a,
  input  logic [7:0]     fe_d,
  output logic           fe_gnt,
  output logic           fe_vld,
  output logic [1:0]     beat,
  output logic [7:0]     rdata,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_we,
  output logic [7:0]     mem_vi,
  input  logic [7:0]     mem_vo,
  output logic [1:0]     owner,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_BT, OWN_LS, OWN_FE} own_t;

  state_t         state_q, state_d;
  own_t           owner_q, pick;
  logic [ASZ-1:0] addr_q, sel_a;
  logic [1:0]     len_q, sel_len, beat_q;
  logic           we_q, sel_we, load;
  logic [2:0]     vld_q;

`ifdef EJ32_ARB_RR_EN
  // Last ls/fe winner: 1 = fe won last, 0 = ls won last.
  logic last_fe_q;

  // Remember which of ls/fe took the most recent grant; bt grants leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fe_q <= 1'b1;
    end else if (load && pick == OWN_LS) begin
      last_fe_q <= 1'b0;
    end else if (load && pick == OWN_FE) begin
      last_fe_q <= 1'b1;
    end
  end
`endif

  // Priority pick among the current requests: bt first, then ls vs fe.
  always_comb begin
    pick = OWN_NONE;
    if (bt_req) begin
      pick = OWN_BT;
    end else if (ls_req && fe_req) begin
`ifdef EJ32_ARB_RR_EN
      pick = last_fe_q ? OWN_LS : OWN_FE;
`else
      pick = OWN_LS;
`endif
    end else if (ls_req) begin
      pick = OWN_LS;
    end else if (fe_req) begin
      pick = OWN_FE;
    end
  end

  // Burst parameters of the picked requester, ready to be latched.
  always_comb begin
    sel_a   = '0;
    sel_len = 2'd0;
    sel_we  = 1'b0;
    case (pick)
      OWN_BT: begin sel_a = bt_a; sel_len = bt_len; sel_we = bt_we; end
      OWN_LS: begin sel_a = ls_a; sel_len = ls_len; sel_we = ls_we; end
      OWN_FE: begin sel_a = fe_a; sel_len = fe_len; sel_we = fe_we; end
      default: ;
    endcase
  end

  // Next-state logic: arbitrate in IDLE, count beats in BURST, and let a
  // still-requesting bt owner chain straight from GAP into a new burst.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick != OWN_NONE) begin
          state_d = S_BURST;
          load    = 1'b1;
        end
      end
      S_BURST: begin
        if (beat_q == len_q) state_d = S_GAP;
      end
      S_GAP: begin
        if (BT_LOCK && owner_q == OWN_BT && bt_req) begin
          state_d = S_BURST;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched burst parameters, beat counter and read-valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      len_q   <= 2'd0;
      we_q    <= 1'b0;
      beat_q  <= 2'd0;
      vld_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      if (load) begin
        owner_q <= pick;
        addr_q  <= sel_a;
        len_q   <= sel_len;
        we_q    <= sel_we;
      end else if (state_d == S_IDLE) begin
        owner_q <= OWN_NONE;
      end
      if (state_q == S_BURST && state_d == S_BURST) begin
        beat_q <= beat_q + 2'd1;
      end else begin
        beat_q <= 2'd0;
      end
      vld_q <= {bt_gnt, ls_gnt, fe_gnt} & {3{~we_q}};
    end
  end

  // Bus drive: only during BURST does the owner see grants and reach SPRAM.
  always_comb begin
    bt_gnt = 1'b0;
    ls_gnt = 1'b0;
    fe_gnt = 1'b0;
    mem_a  = '0;
    mem_we = 1'b0;
    mem_vi = 8'd0;
    if (state_q == S_BURST) begin
      mem_a  = addr_q + ASZ'(beat_q);
      mem_we = we_q;
      case (owner_q)
        OWN_BT: begin bt_gnt = 1'b1; mem_vi = bt_d; end
        OWN_LS: begin ls_gnt = 1'b1; mem_vi = ls_d; end
        OWN_FE: begin fe_gnt = 1'b1; mem_vi = fe_d; end
        default: ;
      endcase
    end
  end

  assign bt_vld = vld_q[2];
  assign ls_vld = vld_q[1];
  assign fe_vld = vld_q[0];
  assign beat   = beat_q;
  assign rdata  = mem_vo;
  assign owner  = owner_q;
  assign busy   = (state_q == S_BURST);

endmodule

// File: tb/tb_ej32_mb8_arb.sv
// tb_ej32_mb8_arb: randomized and directed bench for ej32_mb8_arb.
// A transaction-level schedule model predicts every cycle of bus activity.
module tb_ej32_mb8_arb;

   localparam int ASZ = 17;
   localparam int MSZ = 1 << ASZ;
   localparam bit LOCK = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic bt_req, bt_we, bt_gnt, bt_vld;
   logic ls_req, ls_we, ls_gnt, ls_vld;
   logic fe_req, fe_we, fe_gnt, fe_vld;
   logic [1:0] bt_len, ls_len, fe_len, beat, owner;
   logic [ASZ-1:0] bt_a, ls_a, fe_a, mem_a;
   logic [7:0] bt_d, ls_d, fe_d, rdata, mem_vi, mem_vo;
   logic mem_we, busy;

   // requester agents, index 0 = bt, 1 = ls, 2 = fe
   logic a_act[3];
   logic a_we[3];
   logic [1:0] a_len[3];
   logic [ASZ-1:0] a_a[3];
   logic [7:0] dv[3];
   bit a_go[3], a_done[3], a_dfix[3];
   logic [7:0] a_dbase[3];
   int a_pend[3];
   bit a_auto;

   assign bt_req = a_act[0]; assign bt_we = a_we[0]; assign bt_len = a_len[0]; assign bt_a = a_a[0]; assign bt_d = dv[0];
   assign ls_req = a_act[1]; assign ls_we = a_we[1]; assign ls_len = a_len[1]; assign ls_a = a_a[1]; assign ls_d = dv[1];
   assign fe_req = a_act[2]; assign fe_we = a_we[2]; assign fe_len = a_len[2]; assign fe_a = a_a[2]; assign fe_d = dv[2];

   always #5 clk = ~clk;

   ej32_mb8_arb #(.ASZ(ASZ), .BT_LOCK(LOCK)) dut (
      .clk(clk), .rst(rst),
      .bt_req(bt_req), .bt_we(bt_we), .bt_len(bt_len), .bt_a(bt_a), .bt_d(bt_d), .bt_gnt(bt_gnt), .bt_vld(bt_vld),
      .ls_req(ls_req), .ls_we(ls_we), .ls_len(ls_len), .ls_a(ls_a), .ls_d(ls_d), .ls_gnt(ls_gnt), .ls_vld(ls_vld),
      .fe_req(fe_req), .fe_we(fe_we), .fe_len(fe_len), .fe_a(fe_a), .fe_d(fe_d), .fe_gnt(fe_gnt), .fe_vld(fe_vld),
      .beat(beat), .rdata(rdata), .mem_a(mem_a), .mem_we(mem_we), .mem_vi(mem_vi), .mem_vo(mem_vo),
      .owner(owner), .busy(busy)
   );

   // SPRAM stand-in: samples the bus on the falling edge, read data held for the next cycle
   logic [7:0] spram [MSZ];
   always @(negedge clk) begin
      if (mem_we) spram[mem_a] = mem_vi;
      else mem_vo = spram[mem_a];
   end

   // schedule model: one entry per future cycle of bus activity
   typedef struct {
      int own;
      bit gnt;
      logic [ASZ-1:0] addr;
      bit we;
      int bidx;
      bit last;
   } ent_t;

   ent_t q[$];
   ent_t cur;
   logic [7:0] ref_mem [MSZ];
   int lw;
   int vld_own_n, exp_vld_own;
   logic [7:0] vld_dat_n, exp_vld_dat;
   int total = 0, bad = 0, cyc = 0;

   // observation logs for the hand-computed expectations
   logic [ASZ-1:0] la[$];
   logic [7:0] lv[$], fe_rd[$];
   int fe_g_cyc[$], fe_v_cyc[$], own_log[$];
   int any_gv, bt_g_cnt, fe_g_cnt, fe_in_bt, idle_in_bt, ls_v_cnt;
   bit bt_seen;

   function automatic ent_t mk(int own, bit gnt, logic [ASZ-1:0] addr, bit we, int bidx, bit last);
      ent_t e;
      e.own = own; e.gnt = gnt; e.addr = addr; e.we = we; e.bidx = bidx; e.last = last;
      return e;
   endfunction

   function automatic logic [2:0] onehot(int own);
      if (own == 1) return 3'b100;
      if (own == 2) return 3'b010;
      if (own == 3) return 3'b001;
      return 3'b000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // a granted burst of agent x occupies len+1 beat cycles and one dead cycle
   task automatic push_burst(input int x);
      logic [ASZ-1:0] ad;
      for (int i = 0; i <= int'(a_len[x]); i++) begin
         ad = a_a[x] + ASZ'(i);
         q.push_back(mk(x + 1, 1'b1, ad, a_we[x], i, i == int'(a_len[x])));
      end
      q.push_back(mk(x + 1, 1'b0, '0, 1'b0, 0, 1'b0));
   endtask

   task automatic rand_params(input int x);
      a_we[x] = 1'($urandom);
      a_len[x] = 2'($urandom);
      if ($urandom_range(3) == 0) a_a[x] = ASZ'(MSZ - 1 - $urandom_range(3));
      else a_a[x] = ASZ'($urandom);
   endtask

   task automatic post(input int x, input bit we, input int len, input int adr, input int pend);
      a_we[x] = we;
      a_len[x] = 2'(len);
      a_a[x] = ASZ'(adr);
      a_pend[x] = pend;
      a_go[x] = 1'b1;
   endtask

   task automatic clear_logs();
      la.delete(); lv.delete(); fe_rd.delete();
      fe_g_cyc.delete(); fe_v_cyc.delete(); own_log.delete();
      any_gv = 0; bt_g_cnt = 0; fe_g_cnt = 0; fe_in_bt = 0; idle_in_bt = 0; ls_v_cnt = 0;
      bt_seen = 1'b0;
   endtask

   // inputs for this cycle: agent drops/reloads after a final beat, new requests, write bytes
   task automatic applyStimulus();
      for (int x = 0; x < 3; x++) begin
         if (a_done[x]) begin
            a_done[x] = 1'b0;
            if (a_pend[x] > 0) begin
               a_pend[x]--;
               if (a_auto) rand_params(x);
               else a_a[x] = a_a[x] + ASZ'(a_len[x]) + ASZ'(1);
            end else begin
               a_act[x] = 1'b0;
            end
         end
         if (a_go[x]) begin
            a_go[x] = 1'b0;
            a_act[x] = 1'b1;
         end else if (!a_act[x] && a_auto && $urandom_range(x == 0 ? 40 : (x == 1 ? 3 : 2)) == 0) begin
            rand_params(x);
            a_pend[x] = (x == 0) ? $urandom_range(2) : $urandom_range(1);
            a_act[x] = 1'b1;
         end
         if (a_dfix[x] && cur.gnt && cur.own == x + 1) dv[x] = a_dbase[x] + 8'(cur.bidx);
         else dv[x] = 8'($urandom);
      end
   endtask

   // every output against the model's expectation for this cycle
   task automatic checkOutput();
      logic [7:0] evi;
      evi = 8'd0;
      if (cur.gnt) evi = dv[cur.own - 1];
      chk("gnt", {29'd0, bt_gnt, ls_gnt, fe_gnt}, {29'd0, onehot(cur.gnt ? cur.own : 0)});
      chk("vld", {29'd0, bt_vld, ls_vld, fe_vld}, {29'd0, onehot(exp_vld_own)});
      chk("owner", 32'(owner), 32'(cur.own));
      chk("beat", 32'(beat), cur.gnt ? 32'(cur.bidx) : 32'd0);
      chk("busy", 32'(busy), 32'(cur.gnt));
      chk("mem_we", 32'(mem_we), 32'(cur.gnt && cur.we));
      chk("mem_a", 32'(mem_a), cur.gnt ? 32'(cur.addr) : 32'd0);
      chk("mem_vi", 32'(mem_vi), 32'(evi));
      if (exp_vld_own != 0) chk("rdata", 32'(rdata), 32'(exp_vld_dat));
   endtask

   // model reaction to this cycle: memory effects, arbitration, bt chaining
   task automatic advance();
      int w;
      if (cur.gnt) begin
         if (cur.we) ref_mem[cur.addr] = dv[cur.own - 1];
         else begin
            vld_own_n = cur.own;
            vld_dat_n = ref_mem[cur.addr];
         end
         if (cur.last) a_done[cur.own - 1] = 1'b1;
      end else if (cur.own == 0) begin
         w = -1;
         if (a_act[0]) w = 0;
         else if (a_act[1] && a_act[2]) begin
`ifdef EJ32_ARB_RR_EN
            w = (lw == 2) ? 1 : 2;
`else
            w = 1;
`endif
         end else if (a_act[1]) w = 1;
         else if (a_act[2]) w = 2;
         if (w == 1) lw = 1;
         if (w == 2) lw = 2;
         if (w >= 0) push_burst(w);
      end else if (LOCK && cur.own == 1 && a_act[0]) begin
         push_burst(0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(0, 1'b0, '0, 1'b0, 0, 1'b0);
      exp_vld_own = vld_own_n;
      exp_vld_dat = vld_dat_n;
      vld_own_n = 0;
      applyStimulus();
      #1;
      checkOutput();
      advance();
      if (bt_gnt | ls_gnt | fe_gnt | bt_vld | ls_vld | fe_vld) any_gv++;
      if (ls_gnt) begin la.push_back(mem_a); lv.push_back(mem_vi); end
      if (fe_gnt) begin fe_g_cyc.push_back(cyc); fe_g_cnt++; end
      if (fe_vld) begin fe_v_cyc.push_back(cyc); fe_rd.push_back(rdata); end
      if (ls_vld) ls_v_cnt++;
      if ((bt_gnt | ls_gnt | fe_gnt) && beat == 2'd0) own_log.push_back(int'(owner));
      if (bt_gnt) begin bt_g_cnt++; bt_seen = 1'b1; end
      if (bt_req && fe_gnt) fe_in_bt++;
      if (bt_req && bt_seen && !busy && owner == 2'd0) idle_in_bt++;
   endtask

   // asynchronous reset: outputs must clear at once, model and agents start over
   task automatic do_reset();
      rst = 1'b1;
      for (int x = 0; x < 3; x++) begin
         a_act[x] = 1'b0; a_go[x] = 1'b0; a_done[x] = 1'b0; a_dfix[x] = 1'b0; a_pend[x] = 0;
      end
      #1;
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_gnt", {29'd0, bt_gnt, ls_gnt, fe_gnt}, 32'd0);
      chk("rst_vld", {29'd0, bt_vld, ls_vld, fe_vld}, 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_a", 32'(mem_a), 32'd0);
      q.delete();
      vld_own_n = 0;
      lw = 2;
      clear_logs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_quiet(input string nm, input int maxc);
      int n;
      n = 0;
      while ((a_act[0] || a_act[1] || a_act[2] || a_go[0] || a_go[1] || a_go[2] || q.size() > 0) && n < maxc) begin
         step();
         n++;
      end
      if (n >= maxc) begin
         total++;
         bad++;
         $display("[TB] FAIL %s timeout got=%0d cycles want<%0d", nm, n, maxc);
      end
      repeat (2) step();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n0;
      logic [ASZ-1:0] exp_a [4];
      for (int i = 0; i < MSZ; i++) begin
         spram[i] = 8'(i * 37 + (i >> 9));
         ref_mem[i] = spram[i];
      end
      spram[32'h40] = 8'h5A;
      ref_mem[32'h40] = 8'h5A;
      a_auto = 1'b0;
      for (int x = 0; x < 3; x++) begin
         a_we[x] = 1'b0; a_len[x] = 2'd0; a_a[x] = '0; dv[x] = 8'd0; a_dbase[x] = 8'd0;
      end
      mem_vo = 8'd0;

      $display("[TB] reset and idle");
      do_reset();
      repeat (10) step();
      chk("idle_quiet", 32'(any_gv), 32'd0);

      $display("[TB] ls 4-byte write across the address wrap");
      do_reset();
      a_dfix[1] = 1'b1;
      a_dbase[1] = 8'hA1;
      post(1, 1'b1, 3, 32'h1FFFE, 0);
      run_quiet("ls_write", 20);
      exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
      chk("ls_wr_beats", 32'(la.size()), 32'd4);
      if (la.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("ls_wr_addr", 32'(la[i]), 32'(exp_a[i]));
            chk("ls_wr_byte", 32'(lv[i]), 32'(8'hA1 + 8'(i)));
         end
      end

      $display("[TB] fe 1-byte read");
      do_reset();
      post(2, 1'b0, 0, 32'h40, 0);
      n0 = cyc + 1;
      run_quiet("fe_read", 20);
      chk("fe_gnt_cnt", 32'(fe_g_cyc.size()), 32'd1);
      chk("fe_vld_cnt", 32'(fe_v_cyc.size()), 32'd1);
      if (fe_g_cyc.size() == 1 && fe_v_cyc.size() == 1) begin
         chk("fe_gnt_lat", 32'(fe_g_cyc[0] - n0), 32'd1);
         chk("fe_vld_lat", 32'(fe_v_cyc[0] - n0), 32'd2);
         chk("fe_rdata", 32'(fe_rd[0]), 32'h5A);
      end

      $display("[TB] ls/fe contention");
      do_reset();
      post(1, 1'b0, 1, 32'h100, 3);
      post(2, 1'b0, 0, 32'h200, 3);
      run_quiet("contention", 200);
      chk("cont_bursts", 32'(own_log.size()), 32'd8);
      if (own_log.size() >= 4) begin
`ifdef EJ32_ARB_RR_EN
         chk("cont_own0", 32'(own_log[0]), 32'd2);
         chk("cont_own1", 32'(own_log[1]), 32'd3);
         chk("cont_own2", 32'(own_log[2]), 32'd2);
         chk("cont_own3", 32'(own_log[3]), 32'd3);
`else
         chk("cont_own0", 32'(own_log[0]), 32'd2);
         chk("cont_own1", 32'(own_log[1]), 32'd2);
         chk("cont_own2", 32'(own_log[2]), 32'd2);
         chk("cont_own3", 32'(own_log[3]), 32'd2);
`endif
      end

      $display("[TB] bt lock");
      do_reset();
      post(0, 1'b1, 0, 32'h300, 2);
      post(2, 1'b0, 0, 32'h400, 0);
      run_quiet("bt_lock", 60);
      chk("bt_gnt_cnt", 32'(bt_g_cnt), 32'd3);
      chk("fe_during_bt", 32'(fe_in_bt), 32'd0);
      chk("idle_in_bt", 32'(idle_in_bt), 32'd0);
      chk("fe_after_bt", 32'(fe_g_cnt), 32'd1);

      $display("[TB] reset mid-burst");
      do_reset();
      post(1, 1'b0, 3, 32'h500, 0);
      n0 = 0;
      while (!(cur.gnt && cur.own == 2 && cur.bidx == 1) && n0 < 20) begin
         step();
         n0++;
      end
      chk("reach_beat1", 32'(n0 < 20), 32'd1);
      chk("pre_rst_gnt", 32'(ls_gnt), 32'd1);
      do_reset();
      repeat (6) step();
      chk("no_ls_vld", 32'(ls_v_cnt), 32'd0);
      chk("no_ls_gnt", 32'(la.size()), 32'd0);

      $display("[TB] random traffic");
      do_reset();
      a_auto = 1'b1;
      repeat (3000) step();
      a_auto = 1'b0;
      for (int x = 0; x < 3; x++) a_pend[x] = 0;
      run_quiet("drain", 200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
